pushbutton_debouncer_bank: RTL and testbench

Parametrised multi-channel debouncer for the board's push-buttons and switches. Each channel synchronises an asynchronous, glitchy input into the `clk` domain. It filters the input with a saturation counter and produces a clean level, one-cycle press/release strobes and an optional hold-to-repeat strobe. It sits between the FPGA button pins and the emulator/debugger control logic, which consumes only the strobes and levels.

---
 rtl/pushbutton_debouncer_bank.sv | 163 ++++++++++++++++
 tb/tb_pushbutton_debouncer_bank.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pushbutton_debouncer_bank.sv
// pushbutton_debouncer_bank
// Multi-channel push-button / switch debouncer. Each channel uses a two-flop
// synchroniser and a saturation counter, and produces a clean level plus
// one-cycle press and release strobes.
// Optional feature: define DEBOUNCE_REPEAT_EN to build the hold-to-repeat
// strobe logic. When it is undefined, pb_repeat is tied low and
// REPEAT_DLY/REPEAT_PER have no effect.
module pushbutton_debouncer_bank #(
    parameter int CHANNELS   = 4,
    parameter int CNT_W      = 16,
    parameter int ACTIVE_LOW = 1,
    parameter int REPEAT_DLY = 25_000_000,
    parameter int REPEAT_PER = 5_000_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] pb_in,
    output logic [CHANNELS-1:0] pb_state,
    output logic [CHANNELS-1:0] pb_down,
    output logic [CHANNELS-1:0] pb_up,
    output logic [CHANNELS-1:0] pb_repeat,
    output logic                any_active
);

    // Inverting mask so the rest of the design always sees "1 = pressed"
    localparam logic [CHANNELS-1:0] POL_MASK = (ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [CNT_W-1:0]    CNT_ONE  = 1;

    // Parameter sanity: the filter needs at least a 2-bit counter and the
    // repeat intervals must leave room for a strobe-free gap
    if (CHANNELS < 1 || CNT_W < 2 || REPEAT_DLY < 2 || REPEAT_PER < 2) begin : g_param_check
        $error("pushbutton_debouncer_bank: illegal parameter value");
    end

    logic [CHANNELS-1:0] sync0_q;
    logic [CHANNELS-1:0] sync1_q;
    logic [CNT_W-1:0]    cnt_q [CHANNELS];
    logic [CNT_W-1:0]    cnt_d [CHANNELS];
    logic [CHANNELS-1:0] state_q;
    logic [CHANNELS-1:0] state_d;
    logic [CHANNELS-1:0] down_q;
    logic [CHANNELS-1:0] down_d;
    logic [CHANNELS-1:0] up_q;
    logic [CHANNELS-1:0] up_d;
    logic [CHANNELS-1:0] toggle;
    logic                any_q;

    // Two-flop synchroniser; reset parks both stages at the released level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync0_q <= '0;
            sync1_q <= '0;
        end else begin
            sync0_q <= pb_in ^ POL_MASK;
            sync1_q <= sync0_q;
        end
    end

    // Filter: count while the synchronised input disagrees with the accepted
    // level, accept the new level when the counter has run all the way to ones
    always_comb begin
        for (int ch = 0; ch < CHANNELS; ch++) begin
            cnt_d[ch]   = '0;
            state_d[ch] = state_q[ch];
            toggle[ch]  = 1'b0;
            if (state_q[ch] != sync1_q[ch]) begin
                if (cnt_q[ch] == '1) begin
                    toggle[ch]  = 1'b1;
                    state_d[ch] = ~state_q[ch];
                end else begin
                    cnt_d[ch] = cnt_q[ch] + CNT_ONE;
                end
            end
            down_d[ch] = toggle[ch] & ~state_q[ch];
            up_d[ch]   = toggle[ch] & state_q[ch];
        end
    end

    // Filter counters, accepted levels, edge strobes and the summary flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                cnt_q[ch] <= '0;
            end
            state_q <= '0;
            down_q  <= '0;
            up_q    <= '0;
            any_q   <= 1'b0;
        end else begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                cnt_q[ch] <= cnt_d[ch];
            end
            state_q <= state_d;
            down_q  <= down_d;
            up_q    <= up_d;
            any_q   <= |state_q;
        end
    end

`ifdef DEBOUNCE_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int REP_W   = $clog2(REP_MAX) + 1;
    localparam logic [REP_W-1:0] REP_DLY_LAST = REP_W'(REPEAT_DLY - 1);
    localparam logic [REP_W-1:0] REP_PER_LAST = REP_W'(REPEAT_PER - 1);
    localparam logic [REP_W-1:0] REP_ONE      = 1;

    logic [REP_W-1:0]    rep_cnt_q [CHANNELS];
    logic [REP_W-1:0]    rep_cnt_d [CHANNELS];
    logic [CHANNELS-1:0] rep_first_q;
    logic [CHANNELS-1:0] rep_first_d;
    logic [CHANNELS-1:0] rep_q;
    logic [CHANNELS-1:0] rep_d;

    // Repeat timing: the counter restarts on every strobe. rep_first marks
    // that the long initial delay has elapsed, so later strobes use the short
    // period. Press and release cycles both restart the sequence, and a
    // release cycle never issues a repeat.
    always_comb begin
        for (int ch = 0; ch < CHANNELS; ch++) begin
            rep_cnt_d[ch]   = '0;
            rep_first_d[ch] = 1'b0;
            rep_d[ch]       = 1'b0;
            if (state_q[ch] && !toggle[ch]) begin
                rep_first_d[ch] = rep_first_q[ch];
                if ((!rep_first_q[ch] && rep_cnt_q[ch] == REP_DLY_LAST) ||
                    ( rep_first_q[ch] && rep_cnt_q[ch] == REP_PER_LAST)) begin
                    rep_d[ch]       = 1'b1;
                    rep_first_d[ch] = 1'b1;
                end else begin
                    rep_cnt_d[ch] = rep_cnt_q[ch] + REP_ONE;
                end
            end
        end
    end

    // Repeat counters and the registered repeat strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                rep_cnt_q[ch] <= '0;
            end
            rep_first_q <= '0;
            rep_q       <= '0;
        end else begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                rep_cnt_q[ch] <= rep_cnt_d[ch];
            end
            rep_first_q <= rep_first_d;
            rep_q       <= rep_d;
        end
    end

    assign pb_repeat = rep_q;
`else
    assign pb_repeat = '0;
`endif

    assign pb_state   = state_q;
    assign pb_down    = down_q;
    assign pb_up      = up_q;
    assign any_active = any_q;

endmodule

// File: tb/tb_pushbutton_debouncer_bank.sv
// Testbench for pushbutton_debouncer_bank (CHANNELS=4, CNT_W=4, active-low
// inputs, REPEAT_DLY=40, REPEAT_PER=10). Repeat expectations follow the
// DEBOUNCE_REPEAT_EN macro.
module tb_pushbutton_debouncer_bank;

    localparam int CHANNELS   = 4;
    localparam int CNT_W      = 4;
    localparam int ACTIVE_LOW = 1;
    localparam int REPEAT_DLY = 40;
    localparam int REPEAT_PER = 10;
    localparam int ACCEPT_RUN = 1 << CNT_W;

    logic                clk = 1'b0;
    logic                rst;
    logic [CHANNELS-1:0] pb_in;
    logic [CHANNELS-1:0] pb_state;
    logic [CHANNELS-1:0] pb_down;
    logic [CHANNELS-1:0] pb_up;
    logic [CHANNELS-1:0] pb_repeat;
    logic                any_active;

    int checkCount = 0;
    int errorCount = 0;

    // Reference model state
    logic [CHANNELS-1:0] modelSync0 = '0;
    logic [CHANNELS-1:0] modelSync1 = '0;
    logic [CHANNELS-1:0] modelState = '0;
    logic [CHANNELS-1:0] modelDown  = '0;
    logic [CHANNELS-1:0] modelUp    = '0;
    logic [CHANNELS-1:0] modelRep   = '0;
    logic                modelAny   = 1'b0;
    int                  disagreeRun [CHANNELS];
    int                  pressTime   [CHANNELS];
    int                  modelTime   = 0;

    pushbutton_debouncer_bank #(
        .CHANNELS  (CHANNELS),
        .CNT_W     (CNT_W),
        .ACTIVE_LOW(ACTIVE_LOW),
        .REPEAT_DLY(REPEAT_DLY),
        .REPEAT_PER(REPEAT_PER)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pb_in     (pb_in),
        .pb_state  (pb_state),
        .pb_down   (pb_down),
        .pb_up     (pb_up),
        .pb_repeat (pb_repeat),
        .any_active(any_active)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [CHANNELS-1:0] actual,
                               input logic [CHANNELS-1:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [CHANNELS-1:0] value);
        @(negedge clk);
        pb_in = value;
    endtask

    // Model rules: a level is accepted once the synchronised input has
    // disagreed with it for 2^CNT_W consecutive edges; repeats fall at
    // REPEAT_DLY, REPEAT_DLY+REPEAT_PER, ... edges after the press edge.
    task automatic modelStep();
        int k;
        if (rst) begin
            modelSync0 = '0;
            modelSync1 = '0;
            modelState = '0;
            modelDown  = '0;
            modelUp    = '0;
            modelRep   = '0;
            modelAny   = 1'b0;
            for (int ch = 0; ch < CHANNELS; ch++) begin
                disagreeRun[ch] = 0;
                pressTime[ch]   = 0;
            end
        end else begin
            modelAny = |modelState;
            for (int ch = 0; ch < CHANNELS; ch++) begin
                modelDown[ch] = 1'b0;
                modelUp[ch]   = 1'b0;
                modelRep[ch]  = 1'b0;
                if (modelSync1[ch] != modelState[ch]) begin
                    disagreeRun[ch]++;
                    if (disagreeRun[ch] == ACCEPT_RUN) begin
                        disagreeRun[ch] = 0;
                        modelState[ch]  = ~modelState[ch];
                        if (modelState[ch]) begin
                            modelDown[ch] = 1'b1;
                            pressTime[ch] = modelTime;
                        end else begin
                            modelUp[ch] = 1'b1;
                        end
                    end
                end else begin
                    disagreeRun[ch] = 0;
                end
`ifdef DEBOUNCE_REPEAT_EN
                if (modelState[ch] && !modelDown[ch]) begin
                    k = modelTime - pressTime[ch];
                    modelRep[ch] = (k == REPEAT_DLY) ||
                                   (k > REPEAT_DLY && ((k - REPEAT_DLY) % REPEAT_PER) == 0);
                end
`else
                k = 0;
`endif
            end
            modelSync1 = modelSync0;
            modelSync0 = (ACTIVE_LOW != 0) ? ~pb_in : pb_in;
            modelTime++;
        end
    endtask

    // Advance the model on every rising clock edge and on reset assertion
    initial begin
        forever begin
            @(posedge clk or posedge rst);
            modelStep();
        end
    end

    // Compare every output against the model on each falling edge
    initial begin
        forever begin
            @(negedge clk);
            checkOutput("pb_state", pb_state, modelState);
            checkOutput("pb_down", pb_down, modelDown);
            checkOutput("pb_up", pb_up, modelUp);
            checkOutput("pb_repeat", pb_repeat, modelRep);
            checkOutput("any_active", {3'b000, any_active}, {3'b000, modelAny});
        end
    end

    // Directed stimulus with hand-computed expectations
    initial begin
        int widths [3];
        widths = '{1, 8, 15};
        rst   = 1'b1;
        pb_in = 4'hF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // Clean press on ch0, then clean release
        applyStimulus(4'hE);
        repeat (17) @(posedge clk);
        #1;
        checkOutput("press_e17_down", pb_down, 4'h0);
        checkOutput("press_e17_state", pb_state, 4'h0);
        @(posedge clk);
        #1;
        checkOutput("press_e18_down", pb_down, 4'h1);
        checkOutput("press_e18_state", pb_state, 4'h1);
        checkOutput("press_e18_any", {3'b000, any_active}, 4'h0);
        @(posedge clk);
        #1;
        checkOutput("press_e19_down", pb_down, 4'h0);
        checkOutput("press_e19_any", {3'b000, any_active}, 4'h1);
        applyStimulus(4'hF);
        repeat (17) @(posedge clk);
        #1;
        checkOutput("release_e17_up", pb_up, 4'h0);
        checkOutput("release_e17_state", pb_state, 4'h1);
        @(posedge clk);
        #1;
        checkOutput("release_e18_up", pb_up, 4'h1);
        checkOutput("release_e18_state", pb_state, 4'h0);
        @(posedge clk);
        #1;
        checkOutput("release_e19_up", pb_up, 4'h0);
        repeat (5) @(negedge clk);

        // Asynchronous reset while a press strobe is showing
        applyStimulus(4'hE);
        repeat (18) @(posedge clk);
        #1;
        checkOutput("async_pre_state", pb_state, 4'h1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_state", pb_state, 4'h0);
        checkOutput("async_down", pb_down, 4'h0);
        @(negedge clk);
        rst   = 1'b0;
        pb_in = 4'hF;
        repeat (100) @(negedge clk);
        checkOutput("idle_state", pb_state, 4'h0);

        // Glitch rejection on ch1, then a pulse just long enough to accept
        foreach (widths[i]) begin
            applyStimulus(4'hD);
            repeat (widths[i]) @(negedge clk);
            pb_in = 4'hF;
            repeat (20) @(negedge clk);
            checkOutput("glitch_state", pb_state, 4'h0);
        end
        applyStimulus(4'hD);
        repeat (16) @(negedge clk);
        pb_in = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("pulse16_state", pb_state, 4'h2);
        checkOutput("pulse16_down", pb_down, 4'h2);
        repeat (40) @(negedge clk);
        checkOutput("pulse16_released", pb_state, 4'h0);

        // ch2 and ch3 together while ch0 bounces every 3 cycles
        applyStimulus(4'h3);
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk);
            #1;
            if (e == 17) checkOutput("simul_e17_down", pb_down, 4'h0);
            if (e == 18) checkOutput("simul_e18_down", pb_down, 4'hC);
            @(negedge clk);
            if (e % 3 == 0) pb_in[0] = ~pb_in[0];
        end
        pb_in[0] = 1'b1;
        @(negedge clk);
        checkOutput("simul_state", pb_state, 4'hC);
        applyStimulus(4'hF);
        repeat (25) @(negedge clk);

        // Reset in the middle of a count on ch0
        applyStimulus(4'hE);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (17) @(posedge clk);
        #1;
        checkOutput("midrst_e17_down", pb_down, 4'h0);
        @(posedge clk);
        #1;
        checkOutput("midrst_e18_down", pb_down, 4'h1);
        applyStimulus(4'hF);
        repeat (25) @(negedge clk);

        // Long hold on ch0, release timed so the up strobe lands on a repeat slot
        applyStimulus(4'hE);
        for (int e = 1; e <= 95; e++) begin
            @(posedge clk);
            #1;
            if (e == 18) checkOutput("hold_e18_rep", pb_repeat, 4'h0);
`ifdef DEBOUNCE_REPEAT_EN
            if (e == 57) checkOutput("hold_e57_rep", pb_repeat, 4'h0);
            if (e == 58) checkOutput("hold_e58_rep", pb_repeat, 4'h1);
            if (e == 68) checkOutput("hold_e68_rep", pb_repeat, 4'h1);
            if (e == 78) checkOutput("hold_e78_rep", pb_repeat, 4'h1);
`else
            if (e == 58) checkOutput("hold_e58_rep", pb_repeat, 4'h0);
`endif
            if (e == 88) begin
                checkOutput("hold_e88_up", pb_up, 4'h1);
                checkOutput("hold_e88_rep", pb_repeat, 4'h0);
            end
            if (e == 70) begin
                @(negedge clk);
                pb_in = 4'hF;
            end
        end
        repeat (10) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
